// File: rtl/wb_matmul_engine.sv
// wb_matmul_engine: Wishbone-slave N x N integer matrix multiplier computing C = A * B with a
// single sequential multiply-accumulate. The bus maps a CTRL/STATUS register pair plus the A, B
// (read/write) and C (read-only) element arrays, all row-major, one element per word.
module wb_matmul_engine #(
  parameter int unsigned N      = 3,
  parameter int unsigned DW     = 8,
  parameter int unsigned ACC_W  = 2 * DW + $clog2(N),
  parameter int unsigned A_BASE = 64,
  parameter int unsigned B_BASE = 128,
  parameter int unsigned C_BASE = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] adr,
  input  logic [31:0] dat_mosi,
  output logic [31:0] dat_miso,
  output logic        ack,
  output logic        err,
  output logic        irq,
  output logic        busy
);

  localparam int unsigned NN = N * N;
  localparam int unsigned AW = $clog2(NN);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned PW = 2 * DW;

  typedef enum logic {StIdle, StRun} state_e;

  // Element storage
  logic [DW-1:0]    a_q [NN];
  logic [DW-1:0]    b_q [NN];
  logic [ACC_W-1:0] c_q [NN];

  // Control / status
  logic irq_en_q, signed_q;
  logic done_q, done_d;

  // Bus response
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  // Sequencer
  state_e           state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             c_we, mac_last;

  // Bus decode
  logic          req;
  logic          hit_ctrl, hit_stat, hit_a, hit_b, hit_c;
  logic [AW-1:0] a_bus_idx, b_bus_idx, c_bus_idx;
  logic          a_we, b_we, ctrl_we, stat_we, start;
  logic [31:0]   rdata;

  // Datapath
  logic [AW-1:0]    a_mac_idx, b_mac_idx, c_widx;
  logic [DW-1:0]    a_el, b_el;
  logic [PW-1:0]    a_ext, b_ext, prod;
  logic [ACC_W-1:0] prod_ext, acc_next;

  // Only the low select bit and a few data bits carry meaning here
  logic unused_bits;
  assign unused_bits = ^{wb_sel[3:1], dat_mosi};

  assign busy     = (state_q == StRun);
  assign irq      = done_q & irq_en_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign dat_miso = dat_q;

  assign req      = cyc & stb & ~ack_q & ~err_q;
  assign hit_ctrl = (adr == 32'd0);
  assign hit_stat = (adr == 32'd1);
  assign hit_a    = (adr >= A_BASE) && (adr < A_BASE + NN);
  assign hit_b    = (adr >= B_BASE) && (adr < B_BASE + NN);
  assign hit_c    = (adr >= C_BASE) && (adr < C_BASE + NN);

  assign a_bus_idx = AW'(adr - A_BASE);
  assign b_bus_idx = AW'(adr - B_BASE);
  assign c_bus_idx = AW'(adr - C_BASE);

  // Request decode: pick ack or err, select read data and raise write enables
  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    ctrl_we = 1'b0;
    stat_we = 1'b0;
    rdata   = '0;
    if (req) begin
      if (hit_ctrl) begin
        ack_d   = 1'b1;
        ctrl_we = we;
        rdata   = {29'd0, signed_q, irq_en_q, 1'b0};
      end else if (hit_stat) begin
        ack_d   = 1'b1;
        stat_we = we;
        rdata   = {30'd0, done_q, busy};
      end else if (hit_a) begin
        if (we && busy) begin
          err_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          a_we  = we & wb_sel[0];
          rdata = 32'(a_q[a_bus_idx]);
        end
      end else if (hit_b) begin
        if (we && busy) begin
          err_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          b_we  = we & wb_sel[0];
          rdata = 32'(b_q[b_bus_idx]);
        end
      end else if (hit_c) begin
        // C is read-only, and its contents are in flux while running
        if (we || busy) begin
          err_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          rdata = 32'(c_q[c_bus_idx]);
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Read data only changes on an acknowledged read
  always_comb begin
    dat_d = dat_q;
    if (ack_d && !we) begin
      dat_d = rdata;
    end
  end

  // Bus response registers: one-cycle ack/err pulse after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  assign start = ctrl_we & wb_sel[0] & dat_mosi[0] & ~busy;

  // CTRL fields; the signed mode is frozen while a computation is running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      signed_q <= 1'b0;
    end else if (ctrl_we && wb_sel[0]) begin
      irq_en_q <= dat_mosi[1];
      if (!busy) begin
        signed_q <= dat_mosi[2];
      end
    end
  end

  // Sticky done: completion beats a same-cycle clear
  always_comb begin
    done_d = done_q;
    if (stat_we && wb_sel[0] && dat_mosi[1]) begin
      done_d = 1'b0;
    end
    if (start) begin
      done_d = 1'b0;
    end
    if (mac_last) begin
      done_d = 1'b1;
    end
  end

  // Done flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  // Operand arrays, bus-written only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < NN; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
    end else begin
      if (a_we) begin
        a_q[a_bus_idx] <= dat_mosi[DW-1:0];
      end
      if (b_we) begin
        b_q[b_bus_idx] <= dat_mosi[DW-1:0];
      end
    end
  end

  assign a_mac_idx = AW'(32'(i_q) * N + 32'(k_q));
  assign b_mac_idx = AW'(32'(k_q) * N + 32'(j_q));
  assign c_widx    = AW'(32'(i_q) * N + 32'(j_q));
  assign a_el      = a_q[a_mac_idx];
  assign b_el      = b_q[b_mac_idx];

  // Extending both operands to 2*DW makes the low 2*DW product bits exact in either mode
  assign a_ext    = signed_q ? {{DW{a_el[DW-1]}}, a_el} : {{DW{1'b0}}, a_el};
  assign b_ext    = signed_q ? {{DW{b_el[DW-1]}}, b_el} : {{DW{1'b0}}, b_el};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W - PW){signed_q & prod[PW-1]}}, prod};
  assign acc_next = acc_q + prod_ext;

  // Sequencer next state: k innermost, then j, then i; one MAC per RUN cycle
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    c_we     = 1'b0;
    mac_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      StRun: begin
        acc_d = acc_next;
        if (k_q == IW'(N - 1)) begin
          c_we  = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (j_q == IW'(N - 1)) begin
            j_d = '0;
            if (i_q == IW'(N - 1)) begin
              i_d      = '0;
              state_d  = StIdle;
              mac_last = 1'b1;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // Result array: each element is replaced as its dot product completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < NN; e++) begin
        c_q[e] <= '0;
      end
    end else if (c_we) begin
      c_q[c_widx] <= acc_next;
    end
  end

endmodule

// File: tb/tb_wb_matmul_engine.sv
// Directed self-checking bench for wb_matmul_engine at N=3, DW=8 (ACC_W=18).
module tb_wb_matmul_engine;

  localparam int unsigned N      = 3;
  localparam int unsigned DW     = 8;
  localparam int unsigned ACC_W  = 2 * DW + $clog2(N);
  localparam int unsigned A_BASE = 64;
  localparam int unsigned B_BASE = 128;
  localparam int unsigned C_BASE = 192;

  logic        clk, rst, cyc, stb, we, ack, err, irq, busy;
  logic [3:0]  wb_sel;
  logic [31:0] adr, dat_mosi, dat_miso;

  int checks   = 0;
  int failures = 0;

  wb_matmul_engine #(
    .N      (N),
    .DW     (DW),
    .ACC_W  (ACC_W),
    .A_BASE (A_BASE),
    .B_BASE (B_BASE),
    .C_BASE (C_BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cyc      (cyc),
    .stb      (stb),
    .we       (we),
    .wb_sel   (wb_sel),
    .adr      (adr),
    .dat_mosi (dat_mosi),
    .dat_miso (dat_miso),
    .ack      (ack),
    .err      (err),
    .irq      (irq),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus transfer; returns 1ns after the edge that registers the response
  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd,
                          output logic got_ack, output logic got_err);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_mosi = d; wb_sel = s;
    @(posedge clk); #1;
    got_ack = ack; got_err = err; rd = dat_miso;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    logic        unused_ak, unused_er;
    bus_xfer(1'b1, a, d, 4'hF, unused_rd, unused_ak, unused_er);
  endtask

  // Counts 1ns-after-edge samples with busy high, bounded at 200
  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic ak, er;
    checks++;
    if ({ack, err, irq, busy} !== 4'b0000 || dat_miso !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ack/err/irq/busy=%b dat=%h required 0000 dat=0",
               {ack, err, irq, busy}, dat_miso);
    end
    rst = 1'b0;
    bus_xfer(1'b0, 32'd0, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL reset_ctrl: got ack=%b data=%h required ack=1 data=0", ak, rd);
    end
    bus_xfer(1'b0, 32'd1, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL reset_status: got ack=%b data=%h required ack=1 data=0", ak, rd);
    end
    bus_xfer(1'b0, C_BASE + 4, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL reset_c: got ack=%b data=%h required ack=1 data=0", ak, rd);
    end
  endtask

  task automatic test_identity();
    int a_m [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int cnt;
    logic [31:0] rd;
    logic ak, er;
    for (int e = 0; e < 9; e++) begin
      wr(A_BASE + e, a_m[e]);
      wr(B_BASE + e, e + 1);
    end
    wr(32'd0, 32'h1);
    wait_busy(cnt);
    checks++;
    if (cnt != 27) begin
      failures++; $display("FAIL identity_busy_cycles: got %0d required 27", cnt);
    end
    bus_xfer(1'b0, 32'd1, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h2) begin
      failures++; $display("FAIL identity_status: got ack=%b data=%h required ack=1 data=2", ak, rd);
    end
    // I * B = B = 1..9
    for (int e = 0; e < 9; e++) begin
      bus_xfer(1'b0, C_BASE + e, 32'd0, 4'hF, rd, ak, er);
      checks++;
      if (ak !== 1'b1 || rd !== 32'(e + 1)) begin
        failures++;
        $display("FAIL identity_c%0d: got ack=%b data=%h required ack=1 data=%h", e, ak, rd,
                 32'(e + 1));
      end
    end
  endtask

  task automatic test_errors_busy();
    int cnt;
    logic [31:0] rd;
    logic ak, er;
    wr(32'd0, 32'h1);
    bus_xfer(1'b1, A_BASE, 32'h55, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b0 || er !== 1'b1) begin
      failures++; $display("FAIL busy_write_a: got ack=%b err=%b required ack=0 err=1", ak, er);
    end
    bus_xfer(1'b0, C_BASE, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b0 || er !== 1'b1) begin
      failures++; $display("FAIL busy_read_c: got ack=%b err=%b required ack=0 err=1", ak, er);
    end
    // irq_en=1, signed=1, no start: only irq_en may change while running
    bus_xfer(1'b1, 32'd0, 32'h6, 4'hF, rd, ak, er);
    bus_xfer(1'b0, 32'd0, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h2) begin
      failures++; $display("FAIL busy_ctrl: got ack=%b data=%h required ack=1 data=2", ak, rd);
    end
    bus_xfer(1'b0, A_BASE + 4, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd1) begin
      failures++; $display("FAIL busy_read_a: got ack=%b data=%h required ack=1 data=1", ak, rd);
    end
    wait_busy(cnt);
    checks++;
    if (cnt >= 200) begin
      failures++; $display("FAIL busy_timeout: busy still high after %0d cycles", cnt);
    end
    bus_xfer(1'b0, A_BASE, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd1) begin
      failures++; $display("FAIL busy_a_kept: got ack=%b data=%h required ack=1 data=1", ak, rd);
    end
    bus_xfer(1'b0, C_BASE + 4, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd5) begin
      failures++; $display("FAIL busy_c4: got ack=%b data=%h required ack=1 data=5", ak, rd);
    end
  endtask

  task automatic test_errors_idle();
    logic [31:0] rd;
    logic ak, er;
    // C occupies 192..200; 201 is the first unmapped word above it
    bus_xfer(1'b0, 32'd200, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd9) begin
      failures++; $display("FAIL idle_c8: got ack=%b data=%h required ack=1 data=9", ak, rd);
    end
    bus_xfer(1'b0, 32'd201, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (er !== 1'b1 || ak !== 1'b0 || rd !== 32'd9) begin
      failures++;
      $display("FAIL idle_adr201: got ack=%b err=%b data=%h required ack=0 err=1 data=9",
               ak, er, rd);
    end
    bus_xfer(1'b0, 32'd2, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (er !== 1'b1 || ak !== 1'b0) begin
      failures++; $display("FAIL idle_adr2: got ack=%b err=%b required ack=0 err=1", ak, er);
    end
    bus_xfer(1'b0, A_BASE + 9, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (er !== 1'b1 || ak !== 1'b0) begin
      failures++; $display("FAIL idle_a_end: got ack=%b err=%b required ack=0 err=1", ak, er);
    end
    bus_xfer(1'b1, C_BASE, 32'h123, 4'hF, rd, ak, er);
    checks++;
    if (er !== 1'b1 || ak !== 1'b0) begin
      failures++; $display("FAIL idle_write_c: got ack=%b err=%b required ack=0 err=1", ak, er);
    end
    bus_xfer(1'b0, C_BASE, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd1) begin
      failures++; $display("FAIL idle_c0_kept: got ack=%b data=%h required ack=1 data=1", ak, rd);
    end
    bus_xfer(1'b1, A_BASE + 1, 32'h77, 4'h0, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0) begin
      failures++; $display("FAIL idle_sel0_ack: got ack=%b err=%b required ack=1 err=0", ak, er);
    end
    bus_xfer(1'b0, A_BASE + 1, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (rd !== 32'd0) begin
      failures++; $display("FAIL idle_sel0_nowrite: got %h required 0", rd);
    end
    wr(B_BASE + 2, 32'hFFFF_FFAB);
    bus_xfer(1'b0, B_BASE + 2, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'h0000_00AB) begin
      failures++; $display("FAIL idle_b_zext: got ack=%b data=%h required ack=1 data=000000ab",
                           ak, rd);
    end
  endtask

  task automatic test_signed();
    int cnt;
    logic [31:0] rd;
    logic ak, er;
    for (int e = 0; e < 9; e++) begin
      wr(A_BASE + e, 32'hFF);
      wr(B_BASE + e, 32'h02);
    end
    wr(32'd0, 32'h5);
    wait_busy(cnt);
    checks++;
    if (cnt != 27) begin
      failures++; $display("FAIL signed_busy_cycles: got %0d required 27", cnt);
    end
    // 3 * (-1 * 2) = -6 as an 18-bit pattern, zero-extended on the bus
    for (int e = 0; e < 9; e++) begin
      bus_xfer(1'b0, C_BASE + e, 32'd0, 4'hF, rd, ak, er);
      checks++;
      if (ak !== 1'b1 || rd !== 32'h0003_FFFA) begin
        failures++;
        $display("FAIL signed_c%0d: got ack=%b data=%h required ack=1 data=0003fffa", e, ak, rd);
      end
    end
  endtask

  task automatic test_unsigned();
    int cnt;
    logic [31:0] rd;
    logic ak, er;
    for (int e = 0; e < 9; e++) begin
      wr(A_BASE + e, 32'hFF);
      wr(B_BASE + e, 32'hFF);
    end
    wr(32'd0, 32'h1);
    wait_busy(cnt);
    // 3 * 255 * 255 = 195075
    for (int e = 0; e < 9; e++) begin
      bus_xfer(1'b0, C_BASE + e, 32'd0, 4'hF, rd, ak, er);
      checks++;
      if (ak !== 1'b1 || rd !== 32'd195075) begin
        failures++;
        $display("FAIL unsigned_c%0d: got ack=%b data=%0d required ack=1 data=195075", e, ak, rd);
      end
    end
  endtask

  task automatic test_irq();
    int cnt;
    logic early;
    logic [31:0] rd;
    logic ak, er;
    wr(32'd0, 32'h3);
    early = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (irq !== 1'b0) early = 1'b1;
      cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (early !== 1'b0 || cnt != 27) begin
      failures++; $display("FAIL irq_while_busy: got early=%b cycles=%0d required 0 and 27",
                           early, cnt);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_on_done: got %b required 1", irq);
    end
    bus_xfer(1'b1, 32'd1, 32'h2, 4'hF, rd, ak, er);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_cleared: got %b required 0", irq);
    end
    bus_xfer(1'b0, 32'd1, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (rd !== 32'd0) begin
      failures++; $display("FAIL irq_status_cleared: got %h required 0", rd);
    end
    // Clear write accepted on the same edge as the final MAC
    wr(32'd0, 32'h3);
    repeat (25) @(posedge clk);
    bus_xfer(1'b1, 32'd1, 32'h2, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || busy !== 1'b0 || irq !== 1'b1) begin
      failures++; $display("FAIL irq_coincident: got ack=%b busy=%b irq=%b required 1 0 1",
                           ak, busy, irq);
    end
    bus_xfer(1'b0, 32'd1, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (rd !== 32'h2) begin
      failures++; $display("FAIL irq_coincident_status: got %h required 2", rd);
    end
  endtask

  task automatic test_reset_mid_run();
    int cnt;
    logic [31:0] rd;
    logic ak, er;
    wr(32'd0, 32'h3);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || irq !== 1'b0) begin
      failures++; $display("FAIL rst_async: got busy=%b irq=%b required 0 0", busy, irq);
    end
    @(posedge clk); #1 rst = 1'b0;
    bus_xfer(1'b0, 32'd1, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (ak !== 1'b1 || rd !== 32'd0) begin
      failures++; $display("FAIL rst_status: got ack=%b data=%h required ack=1 data=0", ak, rd);
    end
    for (int e = 0; e < 9; e += 4) begin
      bus_xfer(1'b0, C_BASE + e, 32'd0, 4'hF, rd, ak, er);
      checks++;
      if (ak !== 1'b1 || rd !== 32'd0) begin
        failures++; $display("FAIL rst_c%0d: got ack=%b data=%h required ack=1 data=0", e, ak, rd);
      end
    end
    bus_xfer(1'b0, A_BASE, 32'd0, 4'hF, rd, ak, er);
    checks++;
    if (rd !== 32'd0) begin
      failures++; $display("FAIL rst_a0: got %h required 0", rd);
    end
    // Fresh run: (2*I) * B = 2*B
    for (int e = 0; e < 9; e++) begin
      wr(A_BASE + e, (e % 4 == 0) ? 32'd2 : 32'd0);
      wr(B_BASE + e, e + 1);
    end
    wr(32'd0, 32'h1);
    wait_busy(cnt);
    checks++;
    if (cnt != 27) begin
      failures++; $display("FAIL rerun_busy_cycles: got %0d required 27", cnt);
    end
    for (int e = 0; e < 9; e++) begin
      bus_xfer(1'b0, C_BASE + e, 32'd0, 4'hF, rd, ak, er);
      checks++;
      if (ak !== 1'b1 || rd !== 32'(2 * (e + 1))) begin
        failures++;
        $display("FAIL rerun_c%0d: got ack=%b data=%h required ack=1 data=%h", e, ak, rd,
                 32'(2 * (e + 1)));
      end
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_sel = 4'h0; adr = 32'd0; dat_mosi = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_identity();
    test_errors_busy();
    test_errors_idle();
    test_signed();
    test_unsigned();
    test_irq();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
